// File: rtl/ram5.sv
// ----------------------------------------------------------------------------
// ram5 -- 32-word x 8-bit simple dual-address RAM, flip-flop based.
//
// One write port and one read port.
// Both are addressed independently and serviced on every rising clock edge.
// There is no write enable: each active edge stores in_data at in_address.
// The read is registered (1-cycle latency).
// When the read and write addresses match, the read returns the data being
// written on that same edge (write-first bypass).
// A synchronous active-low reset clears the whole array and the read register.
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  synchronous reset, active-low; has priority over write/read
//   in_address   in   5  write address
//   out_address  in   5  read address
//   in_data      in   8  write data
//   out_data     out  8  registered read data
// ----------------------------------------------------------------------------
module ram5 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] in_address,
    input  logic [4:0] out_address,
    input  logic [7:0] in_data,
    output logic [7:0] out_data
);

    localparam int DEPTH = 32;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;
    logic [7:0] rd_d;

    // Write-first: a same-address read sees the incoming write data, not the
    // stale array contents.
    always_comb begin
        rd_d = mem_q[out_address];
        if (out_address == in_address) begin
            rd_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            rd_q <= 8'd0;
        end else begin
            mem_q[in_address] <= in_data;
            rd_q              <= rd_d;
        end
    end

    assign out_data = rd_q;

endmodule

// File: tb/tb_ram5.sv
// ----------------------------------------------------------------------------
// tb_ram5 -- self-checking bench for ram5.
// Directed steps from the test plan, followed by randomized traffic.
// All traffic is checked against a plain array model of the memory.
// ----------------------------------------------------------------------------
module tb_ram5;

    logic       clk;
    logic       rst_n;
    logic [4:0] in_address;
    logic [4:0] out_address;
    logic [7:0] in_data;
    logic [7:0] out_data;

    int n_cmp;
    int n_bad;

    // Reference model: the memory contents and the expected read register.
    logic [7:0] ref_mem [32];
    logic [7:0] ref_out;

    ram5 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_address  (in_address),
        .out_address (out_address),
        .in_data     (in_data),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock edge.
    // Inputs are driven away from the edge, the model is advanced with the
    // spec's rules, and the output is sampled 1 time unit after the edge.
    // A cexp of -1 means there is no additional constant expectation.
    task automatic step(input logic rn, input logic [4:0] wa, input logic [4:0] ra,
                        input logic [7:0] wd, input string tag, input int cexp);
        rst_n       = rn;
        in_address  = wa;
        out_address = ra;
        in_data     = wd;
        @(posedge clk);
        if (!rn) begin
            foreach (ref_mem[i]) ref_mem[i] = 8'd0;
            ref_out = 8'd0;
        end else begin
            ref_out     = (ra == wa) ? wd : ref_mem[ra];
            ref_mem[wa] = wd;
        end
        #1;
        chk(tag, out_data, ref_out);
        if (cexp >= 0) chk({tag, "_const"}, out_data, 8'(cexp));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_address = '0;
        out_address = '0;
        in_data = '0;
        ref_out = '0;
        foreach (ref_mem[i]) ref_mem[i] = 8'd0;
        @(negedge clk);

        // Reset held for two cycles, then read back cleared locations.
        step(1'b0, 5'd0, 5'd0, 8'hFF, "rst0", 0);
        step(1'b0, 5'd3, 5'd7, 8'hEE, "rst1", 0);
        step(1'b1, 5'd1, 5'd0, 8'd0, "clr_a0", 0);
        step(1'b1, 5'd1, 5'd4, 8'd0, "clr_a4", 0);
        step(1'b1, 5'd1, 5'd24, 8'd0, "clr_a24", 0);
        step(1'b1, 5'd1, 5'd31, 8'd0, "clr_a31", 0);

        // Write then read.
        step(1'b0, 5'd0, 5'd0, 8'd0, "rst2", 0);
        step(1'b1, 5'd24, 5'd28, 8'd45, "wr1", 0);
        step(1'b1, 5'd4, 5'd24, 8'd124, "wr2", 45);
        step(1'b1, 5'd14, 5'd4, 8'd124, "wr3", 124);

        // out_data must not follow out_address between edges.
        out_address = 5'd24;
        #2;
        chk("stable", out_data, 8'd124);
        @(negedge clk);

        // Same-address bypass, then a normal read of the same location.
        step(1'b1, 5'd9, 5'd9, 8'hA5, "bypass", 8'hA5);
        step(1'b1, 5'd0, 5'd9, 8'h00, "after_byp", 8'hA5);

        // Full sweep: write i*7, then read each location back.
        for (int i = 0; i < 32; i++)
            step(1'b1, 5'(i), 5'((i + 16) % 32), 8'((i * 7) % 256), "sweep_wr", -1);
        for (int i = 0; i < 32; i++)
            step(1'b1, 5'd0, 5'(i), 8'd0, "sweep_rd", (i * 7) % 256);

        // Reset mid-operation wipes everything.
        step(1'b1, 5'd2, 5'd0, 8'h5A, "fill0", -1);
        step(1'b1, 5'd17, 5'd0, 8'h3C, "fill1", -1);
        step(1'b1, 5'd30, 5'd0, 8'hC3, "fill2", -1);
        step(1'b0, 5'd2, 5'd2, 8'hFF, "mid_rst", 0);
        step(1'b1, 5'd1, 5'd2, 8'd0, "mid_rd2", 0);
        step(1'b1, 5'd1, 5'd17, 8'd0, "mid_rd17", 0);
        step(1'b1, 5'd1, 5'd30, 8'd0, "mid_rd30", 0);

        // Overwrite on consecutive edges.
        step(1'b1, 5'd31, 5'd0, 8'h11, "ow1", -1);
        step(1'b1, 5'd31, 5'd0, 8'h22, "ow2", -1);
        step(1'b1, 5'd0, 5'd31, 8'h00, "ow_rd", 8'h22);

        // Randomized traffic with occasional resets and forced address collisions.
        for (int k = 0; k < 400; k++) begin
            logic [4:0] wa;
            logic [4:0] ra;
            logic       rn;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 7) == 0) ? wa : 5'($urandom_range(0, 31));
            rn = ($urandom_range(0, 49) != 0);
            step(rn, wa, ra, 8'($urandom_range(0, 255)), "rand", -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram5.md
# ram5

32-word × 8-bit simple dual-address RAM: one write port and one read port, both addressed independently and serviced every clock. Used as a small scratch/buffer store where a producer writes one location while a consumer reads another in the same cycle. The storage is flip-flop based so the whole array is cleared by reset.

## Interface
- Parameters: none. Depth fixed at 32 words, 5-bit addresses, 8-bit data.
- Port order is clk, rst_n, in_address, out_address, in_data, out_data.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_address  input  5  write address, 0..31.
- out_address  input  5  read address, 0..31.
- in_data  input  8  write data.
- out_data  output  8  registered read data.

## Operation
- Storage: mem[0..31], 8 bits each, implemented as registers.
- No write enable. Every rising edge with rst_n=1 performs mem[in_address] <= in_data.
- Every rising edge with rst_n=1 also performs a read into the out_data register:
  - If out_address != in_address: out_data <= mem[out_address], the pre-edge contents.
  - If out_address == in_address: out_data <= in_data. This is write-first bypass.
- Reset (rst_n=0 at a rising edge):
  - All 32 locations are cleared to 8'd0.
  - out_data is cleared to 8'd0.
  - No write occurs that cycle, and in_data is ignored.
- Reset has priority over the write and the read in the same edge.
- Reset asserted mid-operation loses all stored contents. There is no partial clear.
- Addresses are full range (5 bits cover exactly 32 words). There are no out-of-range cases and no wrap logic.
- Contents persist indefinitely without a write; there is no refresh and no other side effect.
- Before the first reset, memory and out_data are undefined (X in simulation). Benches must reset first.

## Timing
- Write latency: data presented before edge k is stored at edge k.
- Read latency: 1 cycle.
  - out_data after edge k reflects out_address sampled at edge k.
  - That value includes any same-edge write to the same address, via the bypass.
- A read of address A at edge k+1, after a write to A at edge k, returns the new data.
- out_data is stable between edges. It does not change combinationally with out_address.
- After rst_n deasserts, the first edge with rst_n=1 is a normal write/read cycle.

## Test plan
- Reset clear: hold rst_n=0 for 2 cycles, then read addresses 0, 4, 24 and 31 with in_address set to a different address and in_data=0 -> out_data=0 for each read.
- Write then read: after reset, at edge 1 write in_address=24, in_data=45 while reading out_address=28 -> out_data=0. At edge 2 write in_address=4, in_data=124 while reading out_address=24 -> out_data=45. At edge 3 write in_address=14, in_data=124 while reading out_address=4 -> out_data=124.
- Same-address bypass: in_address=out_address=9, in_data=8'hA5 -> out_data=8'hA5 after that edge. The next cycle reads out_address=9 with in_address=0 -> out_data=8'hA5.
- Full sweep: write mem[i]=i*7 mod 256 for i=0..31, then read 0..31 with in_address held at a location rewritten with its own value -> each out_data=i*7 mod 256, one cycle after its address.
- Reset mid-operation: fill several locations, assert rst_n=0 for one edge, then read them back -> all 0, and out_data=0 right after the reset edge.
- Overwrite: write 8'h11 then 8'h22 to address 31 on consecutive edges, then read 31 -> out_data=8'h22.
